// File: rtl/soi_probe_pkg.sv
// Shared types for the signals-of-interest probe bank: request opcodes,
// generator modes and the host-port FSM states.
package soi_probe_pkg;

    typedef enum logic [1:0] {
        OP_READ     = 2'd0,
        OP_WRITE    = 2'd1,
        OP_SET_MODE = 2'd2,
        OP_RSVD     = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'd0,
        MODE_TOGGLE = 2'd1,
        MODE_INCR   = 2'd2,
        MODE_RSVD   = 2'd3
    } mode_e;

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

endpackage

// File: rtl/soi_probe_chan.sv
// One probe channel: value and mode registers plus the autonomous generator.
// Priority on the value register is rst > host write > generator.
module soi_probe_chan
    import soi_probe_pkg::*;
#(
    parameter int               DATA_W   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              mode_ld,
    input  mode_e             mode_in,
    output logic [DATA_W-1:0] value_o
);

    logic [DATA_W-1:0] value_q, value_d;
    mode_e             mode_q, mode_d;

    always_comb begin
        value_d = value_q;
        if (wr_en) begin
            value_d = wr_data;
        end else if (!freeze) begin
            // The reserved mode encoding behaves like HOLD.
            case (mode_q)
                MODE_TOGGLE: value_d = ~value_q;
                MODE_INCR:   value_d = value_q + DATA_W'(1);
                default:     value_d = value_q;
            endcase
        end
    end

    always_comb begin
        mode_d = mode_q;
        if (mode_ld) begin
            mode_d = mode_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            value_q <= INIT_VAL;
            mode_q  <= MODE_TOGGLE;
        end else begin
            value_q <= value_d;
            mode_q  <= mode_d;
        end
    end

    assign value_o = value_q;

endmodule

// File: rtl/soi_probe_bank.sv
// Bank of NUM_CH probe channels behind a single host request/response port.
// Each response carries the free-running cycle stamp taken at request acceptance.
module soi_probe_bank
    import soi_probe_pkg::*;
#(
    parameter int  NUM_CH   = 4,
    parameter int  DATA_W   = 8,
    parameter int  INIT_VAL = 1,
    parameter int  STAMP_W  = 32,
    localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     freeze,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [1:0]               req_op,
    input  logic [CH_W-1:0]          req_ch,
    input  logic [DATA_W-1:0]        req_wdata,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [DATA_W-1:0]        rsp_data,
    output logic                     rsp_err,
    output logic [STAMP_W-1:0]       rsp_stamp,
    output logic [NUM_CH*DATA_W-1:0] soi_o,
    output state_e                   dbg_state
);

    localparam logic [DATA_W-1:0] INIT_TRUNC = DATA_W'(INIT_VAL);

    // Handshake: a request transfers on a clk edge where req_valid && req_ready,
    // a response on an edge where rsp_valid && rsp_ready. req_ready and rsp_valid
    // are flops, never combinational functions of req_* or rsp_ready.
    state_e             state_q, state_d;
    logic               req_ready_q, req_ready_d;
    logic               rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]  rsp_data_q, rsp_data_d;
    logic               rsp_err_q, rsp_err_d;
    logic [STAMP_W-1:0] rsp_stamp_q, rsp_stamp_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;

    logic [DATA_W-1:0]  chan_val [NUM_CH];
    logic [NUM_CH-1:0]  wr_en;
    logic [NUM_CH-1:0]  mode_ld;
    logic [DATA_W-1:0]  sel_val;
    logic               accept;
    logic               ch_ok;
    logic               req_err;
    op_e                req_op_e;
    mode_e              mode_in;

    assign req_op_e = op_e'(req_op);
    assign accept   = req_valid && (state_q == IDLE);
    assign ch_ok    = ({1'b0, req_ch} < (CH_W + 1)'(NUM_CH));
    assign req_err  = !ch_ok || (req_op_e == OP_RSVD);
    // A width cast keeps the mode field well defined even for 1-bit channels.
    assign mode_in  = mode_e'(2'(req_wdata));

    always_comb begin
        wr_en   = '0;
        mode_ld = '0;
        sel_val = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (req_ch == CH_W'(i)) begin
                sel_val    = chan_val[i];
                wr_en[i]   = accept && !req_err && (req_op_e == OP_WRITE);
                mode_ld[i] = accept && !req_err && (req_op_e == OP_SET_MODE);
            end
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        soi_probe_chan #(
            .DATA_W   (DATA_W),
            .INIT_VAL (INIT_TRUNC)
        ) u_chan (
            .clk     (clk),
            .rst     (rst),
            .freeze  (freeze),
            .wr_en   (wr_en[g]),
            .wr_data (req_wdata),
            .mode_ld (mode_ld[g]),
            .mode_in (mode_in),
            .value_o (chan_val[g])
        );
        assign soi_o[g*DATA_W +: DATA_W] = chan_val[g];
    end

    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_data_d  = rsp_data_q;
        rsp_err_d   = rsp_err_q;
        rsp_stamp_d = rsp_stamp_q;
        stamp_d     = stamp_q + STAMP_W'(1);
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d     = RESP;
                    req_ready_d = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_data_d  = req_err ? '0 : sel_val;
                    rsp_err_d   = req_err;
                    rsp_stamp_d = stamp_q;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    req_ready_d = 1'b1;
                    rsp_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
            rsp_stamp_q <= '0;
            stamp_q     <= '0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
            rsp_stamp_q <= rsp_stamp_d;
            stamp_q     <= stamp_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_stamp = rsp_stamp_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_soi_probe_bank.sv
// Bench for soi_probe_bank: a 4-channel and a 3-channel bank share one request
// stream and are both checked every cycle against a behavioural model.
module tb_soi_probe_bank;
  import soi_probe_pkg::*;

  // ---------------- clock / reset / shared stimulus ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, freeze, req_valid, rsp_ready;
  logic [1:0] req_op, req_ch;
  logic [7:0] req_wdata;

  logic        req_ready4, rsp_valid4, rsp_err4;
  logic [7:0]  rsp_data4;
  logic [31:0] rsp_stamp4, soi4;
  state_e      dbg4;

  logic        req_ready3, rsp_valid3, rsp_err3;
  logic [7:0]  rsp_data3;
  logic [31:0] rsp_stamp3;
  logic [23:0] soi3;
  state_e      dbg3;

  soi_probe_bank #(.NUM_CH(4), .DATA_W(8), .INIT_VAL(1), .STAMP_W(32)) dut4 (
    .clk(clk), .rst(rst), .freeze(freeze), .req_valid(req_valid), .req_ready(req_ready4),
    .req_op(req_op), .req_ch(req_ch), .req_wdata(req_wdata), .rsp_valid(rsp_valid4),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data4), .rsp_err(rsp_err4), .rsp_stamp(rsp_stamp4),
    .soi_o(soi4), .dbg_state(dbg4)
  );

  soi_probe_bank #(.NUM_CH(3), .DATA_W(8), .INIT_VAL(1), .STAMP_W(32)) dut3 (
    .clk(clk), .rst(rst), .freeze(freeze), .req_valid(req_valid), .req_ready(req_ready3),
    .req_op(req_op), .req_ch(req_ch), .req_wdata(req_wdata), .rsp_valid(rsp_valid3),
    .rsp_ready(rsp_ready), .rsp_data(rsp_data3), .rsp_err(rsp_err3), .rsp_stamp(rsp_stamp3),
    .soi_o(soi3), .dbg_state(dbg3)
  );

  // ---------------- scoreboard counters ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          nch [2] = '{4, 3};
  logic [7:0]  m_val  [2][4];
  logic [1:0]  m_mode [2][4];
  bit          m_resp [2];
  logic [7:0]  m_rdata [2];
  logic        m_rerr [2];
  logic [31:0] m_rstamp [2];
  logic [31:0] m_stamp;
  bit          started = 0;

  function automatic logic [7:0] gen(input logic [7:0] v, input logic [1:0] mode);
    case (mode)
      2'd1:    return ~v;
      2'd2:    return v + 8'd1;
      default: return v;
    endcase
  endfunction

  always @(posedge clk) begin
    started = 1;
    if (rst) begin
      m_stamp = 0;
      for (int k = 0; k < 2; k++) begin
        m_resp[k] = 0; m_rdata[k] = 0; m_rerr[k] = 0; m_rstamp[k] = 0;
        for (int c = 0; c < 4; c++) begin
          m_val[k][c] = 8'h01; m_mode[k][c] = 2'd1;
        end
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        bit acc, err;
        acc = !m_resp[k] && req_valid;
        err = (int'(req_ch) >= nch[k]) || (req_op == 2'd3);
        if (acc) begin
          m_rdata[k]  = err ? 8'h00 : m_val[k][req_ch];
          m_rerr[k]   = err;
          m_rstamp[k] = m_stamp;
        end
        for (int c = 0; c < nch[k]; c++) begin
          if (acc && !err && req_op == 2'd1 && int'(req_ch) == c) m_val[k][c] = req_wdata;
          else if (!freeze) m_val[k][c] = gen(m_val[k][c], m_mode[k][c]);
        end
        if (acc && !err && req_op == 2'd2) m_mode[k][req_ch] = req_wdata[1:0];
        if (acc) m_resp[k] = 1;
        else if (m_resp[k] && rsp_ready) m_resp[k] = 0;
      end
      m_stamp = m_stamp + 1;
    end
  end

  // ---------------- compare process ----------------
  task automatic cmp_inst(input int k, input logic rr, input logic rv, input logic [7:0] rd,
                          input logic re, input logic [31:0] rs, input logic [31:0] soi,
                          input logic dres);
    check($sformatf("i%0d_req_ready", k), 32'(rr), 32'(!m_resp[k]));
    check($sformatf("i%0d_rsp_valid", k), 32'(rv), 32'(m_resp[k]));
    check($sformatf("i%0d_state", k), 32'(dres), 32'(m_resp[k]));
    for (int c = 0; c < nch[k]; c++)
      check($sformatf("i%0d_soi_ch%0d", k, c), 32'(soi[c*8 +: 8]), 32'(m_val[k][c]));
    if (m_resp[k]) begin
      check($sformatf("i%0d_rsp_data", k), 32'(rd), 32'(m_rdata[k]));
      check($sformatf("i%0d_rsp_err", k), 32'(re), 32'(m_rerr[k]));
      check($sformatf("i%0d_rsp_stamp", k), rs, m_rstamp[k]);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      cmp_inst(0, req_ready4, rsp_valid4, rsp_data4, rsp_err4, rsp_stamp4, soi4, dbg4 == RESP);
      cmp_inst(1, req_ready3, rsp_valid3, rsp_data3, rsp_err3, rsp_stamp3, {8'h00, soi3}, dbg3 == RESP);
    end
  end

  // ---------------- driver tasks ----------------
  bit          rand_rdy = 0;
  logic [7:0]  exp_pre;
  logic [31:0] exp_stamp;

  task automatic tick();
    @(negedge clk);
    if (rand_rdy) rsp_ready = 1'($urandom_range(0, 1));
  endtask

  function automatic logic [7:0] ch4(input int c);
    return soi4[c*8 +: 8];
  endfunction

  // Waits for an idle port, presents one request for exactly one edge.
  task automatic send(input logic [1:0] op, input logic [1:0] ch, input logic [7:0] wd);
    int n = 0;
    while (m_resp[0] && n < 60) begin
      tick();
      n++;
    end
    if (m_resp[0]) begin
      check("send_wait_timeout", 32'(1), 32'(0));
    end else begin
      exp_pre   = m_val[0][ch];
      exp_stamp = m_stamp;
      req_op = op; req_ch = ch; req_wdata = wd; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
    end
  endtask

  // ---------------- main sequence ----------------
  logic [7:0] seq [4] = '{8'h01, 8'hFE, 8'h01, 8'hFE};
  logic [7:0] incr_seq [4] = '{8'hFE, 8'hFF, 8'h00, 8'h01};

  initial begin
    rst = 1'b1; freeze = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    req_op = 2'd0; req_ch = 2'd0; req_wdata = 8'h00;
    repeat (3) tick();

    // reset state
    check("rst_req_ready", 32'(req_ready4), 32'(1));
    check("rst_rsp_valid", 32'(rsp_valid4), 32'(0));
    check("rst_rsp_data", 32'(rsp_data4), 32'(0));
    check("rst_rsp_err", 32'(rsp_err4), 32'(0));
    check("rst_rsp_stamp", rsp_stamp4, 32'(0));
    check("rst_soi", soi4, 32'h01010101);

    // free-running toggle after release
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      for (int c = 0; c < 4; c++) check($sformatf("toggle_c%0d_ch%0d", i, c), 32'(ch4(c)), 32'(seq[i]));
      check("toggle_req_ready", 32'(req_ready4), 32'(1));
      check("toggle_rsp_valid", 32'(rsp_valid4), 32'(0));
    end

    // INCR with wrap on ch1
    send(2'd2, 2'd1, 8'h02);
    send(2'd1, 2'd1, 8'hFE);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) tick();
      check($sformatf("incr_c%0d", i), 32'(ch4(1)), 32'(incr_seq[i]));
    end

    // READ held with rsp_ready low for 3 cycles
    tick();
    rsp_ready = 1'b0;
    send(2'd0, 2'd2, 8'h00);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      check("hold_rsp_valid", 32'(rsp_valid4), 32'(1));
      check("hold_req_ready", 32'(req_ready4), 32'(0));
      check("hold_rsp_data", 32'(rsp_data4), 32'(exp_pre));
      check("hold_rsp_stamp", rsp_stamp4, exp_stamp);
    end
    rsp_ready = 1'b1;
    tick();
    check("release_req_ready", 32'(req_ready4), 32'(1));
    check("release_rsp_valid", 32'(rsp_valid4), 32'(0));

    // WRITE on a toggling channel
    send(2'd1, 2'd3, 8'h5A);
    check("wr_ch3", 32'(ch4(3)), 32'h5A);
    check("wr_pre_value", 32'(rsp_data4), 32'(exp_pre));
    tick();
    check("wr_ch3_toggled", 32'(ch4(3)), 32'hA5);

    // error responses
    send(2'd0, 2'd3, 8'h00);
    check("err_badch_3ch_err", 32'(rsp_err3), 32'(1));
    check("err_badch_3ch_data", 32'(rsp_data3), 32'(0));
    check("err_badch_4ch_err", 32'(rsp_err4), 32'(0));
    send(2'd3, 2'd0, 8'hFF);
    check("err_rsvd_4ch_err", 32'(rsp_err4), 32'(1));
    check("err_rsvd_4ch_data", 32'(rsp_data4), 32'(0));
    check("err_rsvd_3ch_err", 32'(rsp_err3), 32'(1));

    // freeze with write, then reset during a pending response
    freeze = 1'b1;
    send(2'd1, 2'd0, 8'h33);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) tick();
      check("freeze_ch0", 32'(ch4(0)), 32'h33);
    end
    rsp_ready = 1'b0;
    send(2'd0, 2'd1, 8'h00);
    check("pre_rst_rsp_valid", 32'(rsp_valid4), 32'(1));
    rst = 1'b1;
    tick();
    check("midrst_rsp_valid", 32'(rsp_valid4), 32'(0));
    check("midrst_soi", soi4, 32'h01010101);
    rst = 1'b0; freeze = 1'b0; rsp_ready = 1'b1;
    send(2'd0, 2'd0, 8'h00);
    check("post_rst_stamp", rsp_stamp4, 32'(0));
    check("post_rst_data", 32'(rsp_data4), 32'h01);

    // randomized traffic
    rand_rdy = 1;
    repeat (400) begin
      freeze = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 60) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
      repeat ($urandom_range(0, 2)) tick();
    end
    rand_rdy = 0;
    rsp_ready = 1'b1;
    repeat (4) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
